// File: rtl/bcd_counter_multi_pkg.sv
// Shared BCD definitions for the multi-digit counter: digit type, digit
// limits, validity check and reset-value digit extraction.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic is_valid_bcd(input bcd_digit_t digit);
        return digit <= BCD_MAX;
    endfunction

    // Decimal digit k of a plain integer; evaluated at elaboration only.
    function automatic bcd_digit_t rst_digit_of(input int unsigned value,
                                                input int unsigned k);
        int unsigned v;
        v = value;
        for (int unsigned i = 0; i < k; i++) begin
            v = v / 10;
        end
        return bcd_digit_t'(v % 10);
    endfunction

endpackage

// File: rtl/bcd_counter_multi_if.sv
// Control/data bundle of the multi-digit BCD counter.
// master drives count/load controls, slave is the counter.
interface bcd_counter_multi_if #(parameter int DIGITS = 4);

    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   din;
    logic [4*DIGITS-1:0]   q;
    logic                  tc;
    logic                  load_err;

    modport master (output en, up, load, din, input q, tc, load_err);
    modport slave  (input en, up, load, din, output q, tc, load_err);

endinterface

// File: rtl/bcd_counter_multi_digit.sv
// One BCD digit cell: reset, load or step up/down with carry/borrow out.
// Stored values above 9 are treated as 9 counting up and as 0 counting
// down, so a corrupted digit recovers on its next step.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  bcd_digit_t rst_digit,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t d,
    output logic       carry_out
);

    logic at_lim;

    // Digit sits at the rollover point for the current direction.
    assign at_lim    = up ? (d >= BCD_MAX) : ((d == BCD_MIN) || (d > BCD_MAX));
    assign carry_out = step & at_lim;

    // Digit register: reset > load > step > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            d <= rst_digit;
        end else if (ld) begin
            d <= ld_val;
        end else if (step) begin
            if (up) begin
                d <= at_lim ? BCD_MIN : d + 4'd1;
            end else begin
                d <= at_lim ? BCD_MAX : d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_multi.sv
// N-digit synchronous BCD up/down counter with validated parallel load
// and terminal count for cascading.
// Optional build macro BCD_COUNTER_SATURATE_EN: hold at 99..9 / 00..0
// instead of wrapping; tc still flags the limit.
module bcd_counter_multi
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int RST_VAL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_counter_multi_if.slave    bus
);

    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] dig_bad;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic              at_limit;
    logic              count_en;
    logic              unused_top_carry;

    // Whole counter is at the wrap point for the current direction.
    assign at_limit = bus.up ? (&at_max) : (&at_min);
    assign bus.tc   = bus.en & at_limit;

`ifdef BCD_COUNTER_SATURATE_EN
    assign count_en = bus.en & ~at_limit;
`else
    assign count_en = bus.en;
`endif

    // The top digit's carry is the full-wrap event; nothing consumes it.
    assign unused_top_carry = carry[DIGITS-1];

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        localparam bcd_digit_t RST_DIGIT = rst_digit_of(RST_VAL, k);
        bcd_digit_t din_k;
        bcd_digit_t ld_k;
        bcd_digit_t d_k;

        assign din_k      = bus.din[4*k +: 4];
        assign dig_bad[k] = !is_valid_bcd(din_k);
        assign ld_k       = dig_bad[k] ? BCD_MIN : din_k;
        assign at_max[k]  = (d_k == BCD_MAX);
        assign at_min[k]  = (d_k == BCD_MIN);

        if (k == 0) begin : g_first
            assign step[k] = count_en;
        end else begin : g_chain
            assign step[k] = carry[k-1];
        end

        bcd_digit u_digit (
            .clk       (clk),
            .rst       (rst),
            .rst_digit (RST_DIGIT),
            .ld        (bus.load),
            .ld_val    (ld_k),
            .step      (step[k]),
            .up        (bus.up),
            .d         (d_k),
            .carry_out (carry[k])
        );

        assign bus.q[4*k +: 4] = d_k;
    end

    // One-cycle flag after a load that contained a non-BCD digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.load_err <= 1'b0;
        end else begin
            bus.load_err <= bus.load & (|dig_bad);
        end
    end

endmodule
